// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back / register-file slice.
// Widths, enable polarities and the NOP destination used by the WB latch and the array.
package wb_regfile_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int RegNum     = 32;
    localparam int CntBus     = 32;

    localparam logic [RegBus-1:0]     ZeroWord     = '0;
    localparam logic                  RstEnable    = 1'b1;
    localparam logic                  WriteEnable  = 1'b1;
    localparam logic                  WriteDisable = 1'b0;
    localparam logic                  ReadEnable   = 1'b1;
    localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;

endpackage

// File: rtl/wb_regfile_wb_latch.sv
// WB pipeline latch between EX/MEM and the register file.
// A flush loads a bubble and takes priority over a stall.
module wb_latch
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [ADDR_W-1:0] wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o
);

    logic [ADDR_W-1:0] r_wd;
    logic              r_wreg;
    logic [DATA_W-1:0] r_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            r_wd    <= '0;
            r_wreg  <= WriteDisable;
            r_wdata <= '0;
        end else if (flush_i) begin
            r_wd    <= '0;
            r_wreg  <= WriteDisable;
            r_wdata <= '0;
        end else if (!stall_i) begin
            r_wd    <= wd_i;
            r_wreg  <= wreg_i;
            r_wdata <= wdata_i;
        end
    end

    assign wd_o    = r_wd;
    assign wreg_o  = r_wreg;
    assign wdata_o = r_wdata;

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: WB latch, 32-entry register file with x0 tied to zero,
// commit counter and two forwarded combinational read ports for decode.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W    = RegBus,
    parameter int ADDR_W    = RegAddrBus,
    parameter int NUM_REGS  = RegNum,
    parameter int BYPASS_IN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic [ADDR_W-1:0] wb_wd_o,
    output logic              wb_wreg_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic [CntBus-1:0] wb_cnt_o
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [CntBus-1:0] r_cnt;
    logic              w_commit;

    wb_latch #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_wb_latch (
        .clk     (clk),
        .rst     (rst),
        .stall_i (stall_i),
        .flush_i (flush_i),
        .wd_i    (wd_i),
        .wreg_i  (wreg_i),
        .wdata_i (wdata_i),
        .wd_o    (wb_wd_o),
        .wreg_o  (wb_wreg_o),
        .wdata_o (wb_wdata_o)
    );

    // The latch keeps committing while stalled; rewriting the same value is harmless.
    assign w_commit = (wb_wreg_o == WriteEnable) && (wb_wd_o != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_cnt <= '0;
        end else if (w_commit) begin
            r_regs[wb_wd_o] <= wb_wdata_o;
            r_cnt           <= r_cnt + 1'b1;
        end
    end

    assign wb_cnt_o = r_cnt;

    // Later assignments win: un-latched input beats the WB latch, which beats the array.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              re,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] arr
    );
        logic [DATA_W-1:0] v;
        v = arr;
        if (wb_wreg_o == WriteEnable && wb_wd_o == addr) v = wb_wdata_o;
        if (BYPASS_IN != 0 && wreg_i == WriteEnable && wd_i == addr && !flush_i) v = wdata_i;
        if (rst == RstEnable || re != ReadEnable || addr == '0) v = '0;
        return v;
    endfunction

    always_comb begin
        rdata1_o = read_port(re1_i, raddr1_i, r_regs[raddr1_i]);
        rdata2_o = read_port(re2_i, raddr2_i, r_regs[raddr2_i]);
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: two instances (bypass on / off) driven in lockstep
// and compared each cycle against an array-based reference model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0, flush_i = 1'b0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic        re1_i = 1'b0, re2_i = 1'b0;
    logic [4:0]  raddr1_i = '0, raddr2_i = '0;

    logic [31:0] b_rd1, b_rd2, b_wdata, b_cnt;
    logic [4:0]  b_wd;
    logic        b_wreg;
    logic [31:0] n_rd1, n_rd2, n_wdata, n_cnt;
    logic [4:0]  n_wd;
    logic        n_wreg;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    logic [4:0]  m_wd;
    logic        m_wreg;
    logic [31:0] m_data;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .BYPASS_IN(1)) u_byp (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .re1_i(re1_i), .raddr1_i(raddr1_i), .rdata1_o(b_rd1),
        .re2_i(re2_i), .raddr2_i(raddr2_i), .rdata2_o(b_rd2),
        .wb_wd_o(b_wd), .wb_wreg_o(b_wreg), .wb_wdata_o(b_wdata), .wb_cnt_o(b_cnt)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .BYPASS_IN(0)) u_nob (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .re1_i(re1_i), .raddr1_i(raddr1_i), .rdata1_o(n_rd1),
        .re2_i(re2_i), .raddr2_i(raddr2_i), .rdata2_o(n_rd2),
        .wb_wd_o(n_wd), .wb_wreg_o(n_wreg), .wb_wdata_o(n_wdata), .wb_cnt_o(n_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_wd = '0; m_wreg = 1'b0; m_data = '0; m_cnt = '0;
    endtask

    function automatic logic [31:0] m_read(input bit byp, input logic re, input logic [4:0] a);
        if (rst || !re || a == 5'd0) return 32'd0;
        if (byp && wreg_i && wd_i == a && !flush_i) return wdata_i;
        if (m_wreg && m_wd == a) return m_data;
        return m_regs[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            if (m_wreg && m_wd != 5'd0) begin
                m_regs[m_wd] = m_data;
                m_cnt = m_cnt + 32'd1;
            end
            if (flush_i) begin
                m_wd = '0; m_wreg = 1'b0; m_data = '0;
            end else if (!stall_i) begin
                m_wd = wd_i; m_wreg = wreg_i; m_data = wdata_i;
            end
        end
    endtask

    task automatic check_all();
        chk("byp_rd1", b_rd1, m_read(1'b1, re1_i, raddr1_i));
        chk("byp_rd2", b_rd2, m_read(1'b1, re2_i, raddr2_i));
        chk("nob_rd1", n_rd1, m_read(1'b0, re1_i, raddr1_i));
        chk("nob_rd2", n_rd2, m_read(1'b0, re2_i, raddr2_i));
        chk("byp_wd",   {27'd0, b_wd}, {27'd0, m_wd});
        chk("byp_wreg", {31'd0, b_wreg}, {31'd0, m_wreg});
        chk("byp_wdat", b_wdata, m_data);
        chk("byp_cnt",  b_cnt, m_cnt);
        chk("nob_cnt",  n_cnt, m_cnt);
        chk("nob_wdat", n_wdata, m_data);
    endtask

    task automatic to_neg();
        @(negedge clk);
        check_all();
    endtask

    task automatic to_pos();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic st, input logic fl, input logic [4:0] wd, input logic we,
                         input logic [31:0] wdat, input logic r1, input logic [4:0] a1,
                         input logic r2, input logic [4:0] a2);
        stall_i = st; flush_i = fl; wd_i = wd; wreg_i = we; wdata_i = wdat;
        re1_i = r1; raddr1_i = a1; re2_i = r2; raddr2_i = a2;
    endtask

    logic [31:0] cnt0;

    initial begin
        model_reset();
        // Power-on reset
        drive(0, 0, 5'd3, 1, 32'h5555_5555, 1, 5'd3, 1, 5'd3);
        to_neg();
        chk("rst_rd1", b_rd1, 32'd0);
        to_pos();
        rst = 1'b0;
        drive(0, 0, 5'd0, 0, 32'd0, 0, 5'd0, 0, 5'd0);
        to_neg(); to_pos();

        // Basic write with bypass, latch forward, then array
        drive(0, 0, 5'd3, 1, 32'hDEAD_BEEF, 1, 5'd3, 1, 5'd3);
        to_neg();
        chk("basic_byp", b_rd1, 32'hDEAD_BEEF);
        chk("basic_nob_pre", n_rd1, 32'd0);
        to_pos();
        drive(0, 0, 5'd0, 0, 32'd0, 1, 5'd3, 1, 5'd3);
        to_neg();
        chk("basic_nob_latch", n_rd1, 32'hDEAD_BEEF);
        to_pos();
        to_neg();
        chk("basic_array", n_rd1, 32'hDEAD_BEEF);
        chk("basic_cnt", b_cnt, 32'd1);
        to_pos();

        // x0 stays zero, no count
        cnt0 = m_cnt;
        drive(0, 0, 5'd0, 1, 32'hFFFF_FFFF, 1, 5'd0, 1, 5'd0);
        to_neg(); chk("x0_byp", b_rd1, 32'd0); to_pos();
        to_neg(); chk("x0_nob", n_rd2, 32'd0); to_pos();
        drive(0, 0, 5'd0, 0, 32'd0, 1, 5'd0, 1, 5'd0);
        to_neg(); chk("x0_cnt", b_cnt, cnt0); to_pos();

        // Priority: array 0x11, latch 0x22, input 0x33
        drive(0, 0, 5'd7, 1, 32'h11, 1, 5'd7, 0, 5'd7);
        to_neg(); to_pos();
        drive(0, 0, 5'd0, 0, 32'd0, 1, 5'd7, 0, 5'd7);
        to_neg(); to_pos();
        drive(0, 0, 5'd7, 1, 32'h22, 1, 5'd7, 0, 5'd7);
        to_neg(); to_pos();
        drive(0, 0, 5'd7, 1, 32'h33, 1, 5'd7, 0, 5'd7);
        to_neg();
        chk("prio_byp", b_rd1, 32'h33);
        chk("prio_nob", n_rd1, 32'h22);
        chk("prio_re0", b_rd2, 32'd0);
        to_pos();
        drive(0, 0, 5'd0, 0, 32'd0, 1, 5'd7, 0, 5'd7);
        to_neg(); to_pos();

        // Stall holds and keeps committing; flush beats stall
        drive(0, 0, 5'd9, 1, 32'hA5, 1, 5'd9, 1, 5'd9);
        to_neg(); to_pos();
        cnt0 = b_cnt;
        drive(1, 0, 5'd9, 1, 32'hFF, 1, 5'd9, 1, 5'd9);
        for (int i = 0; i < 3; i++) begin
            to_neg(); to_pos();
        end
        to_neg();
        chk("stall_hold", b_wdata, 32'hA5);
        chk("stall_cnt", b_cnt, cnt0 + 32'd3);
        to_pos();
        drive(1, 1, 5'd9, 1, 32'hFF, 1, 5'd9, 1, 5'd9);
        to_neg(); to_pos();
        drive(0, 0, 5'd0, 0, 32'd0, 1, 5'd9, 1, 5'd9);
        to_neg();
        chk("flush_wreg", {31'd0, b_wreg}, 32'd0);
        chk("flush_x9", n_rd1, 32'hA5);
        to_pos();

        // Counter wrap
        @(negedge clk);
        force u_byp.r_cnt = 32'hFFFF_FFFF;
        force u_nob.r_cnt = 32'hFFFF_FFFF;
        #1;
        release u_byp.r_cnt;
        release u_nob.r_cnt;
        m_cnt = 32'hFFFF_FFFF;
        chk("wrap_pre", b_cnt, 32'hFFFF_FFFF);
        to_pos();
        drive(0, 0, 5'd4, 1, 32'h4444, 1, 5'd4, 1, 5'd4);
        to_neg(); to_pos();
        drive(0, 0, 5'd0, 0, 32'd0, 1, 5'd4, 1, 5'd4);
        to_neg(); to_pos();
        to_neg();
        chk("wrap_cnt", b_cnt, 32'd0);
        to_pos();

        // Reset mid-run discards the latched write
        drive(0, 0, 5'd5, 1, 32'h1234, 1, 5'd5, 1, 5'd5);
        to_neg(); to_pos();
        drive(0, 0, 5'd0, 0, 32'd0, 1, 5'd5, 1, 5'd5);
        rst = 1'b1;
        model_reset();
        #1;
        to_neg();
        rst = 1'b0;
        #1;
        to_pos();
        to_neg();
        chk("rst_x5", n_rd1, 32'd0);
        chk("rst_cnt", b_cnt, 32'd0);
        chk("rst_wreg", {31'd0, b_wreg}, 32'd0);
        to_pos();

        // Randomised traffic over a small index set to exercise forwarding
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom(),
                  ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)));
            to_neg();
            to_pos();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
